// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared constants for the display mode controller and the pixel path:
// resolution codes, controller state encoding, counter widths and a helper
// that tells whether a resolution code may be applied to syncgen.
// ---------------------------------------------------------------------------
package disp_pkg;

  typedef logic [1:0] resol_t;

  localparam resol_t RESOL_VGA  = 2'd0;
  localparam resol_t RESOL_XGA  = 2'd1;
  localparam resol_t RESOL_SXGA = 2'd2;
  localparam resol_t RESOL_RSVD = 2'd3;

  // Controller states, kept as plain constants so legacy code can decode them.
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_WAIT_FS = 2'd3;

  localparam int CNT_W   = 11;  // syncgen HCNT/VCNT width
  localparam int HOLD_W  = 8;
  localparam int FRAME_W = 4;
  localparam int TMO_W   = 24;

  // Only the three defined resolutions may ever reach syncgen.
  function automatic logic resol_valid(input resol_t r);
    case (r)
      RESOL_VGA, RESOL_XGA, RESOL_SXGA: return 1'b1;
      RESOL_RSVD:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_start_det.sv
// ---------------------------------------------------------------------------
// frame_start_det
// Flags the first pixel of a frame coming out of syncgen. While syncgen is
// held in reset its counters sit at zero, so the reset input masks the
// detection to avoid reporting a frame start every cycle of the hold.
// Ports:
//   hcnt, vcnt : syncgen horizontal / vertical counters
//   sync_rst   : active-high reset currently applied to syncgen
//   fs         : high for the cycle in which a frame starts
// ---------------------------------------------------------------------------
module frame_start_det
  import disp_pkg::*;
(
  input  logic [CNT_W-1:0] hcnt,
  input  logic [CNT_W-1:0] vcnt,
  input  logic             sync_rst,
  output logic             fs
);

  assign fs = !sync_rst && (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/disp_mode_ctrl.sv
// ---------------------------------------------------------------------------
// disp_mode_ctrl
// Sequences resolution changes and power-up of syncgen: mutes the pixel
// output, waits for a frame boundary, holds syncgen in reset while RESOL
// switches, then re-enables output after BLANK_FRAMES clean frame starts.
// Ports:
//   DCLK, DRST_X          : display clock, synchronous active-low reset
//   REQ_RESOL, REQ_VALID  : resolution request (valid/ready)
//   REQ_READY             : request accepted this cycle when high (RUN only)
//   HCNT, VCNT            : counters from syncgen
//   RESOL, SYNC_RST       : resolution and active-high reset to syncgen
//   DSP_ENABLE            : pixel output gate
//   BUSY, DONE, ERR       : status; DONE/ERR are one-cycle pulses
// All outputs are registered.
// ---------------------------------------------------------------------------
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned      HOLD_CYC     = 16,   // 2..256
  parameter int unsigned      BLANK_FRAMES = 2,    // 1..15
  parameter logic [TMO_W-1:0] TIMEOUT_CYC  = 24'd4_000_000,
  parameter resol_t           DEF_RESOL    = RESOL_VGA
) (
  input  logic             DCLK,
  input  logic             DRST_X,
  input  logic [1:0]       REQ_RESOL,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [CNT_W-1:0] HCNT,
  input  logic [CNT_W-1:0] VCNT,
  output logic [1:0]       RESOL,
  output logic             SYNC_RST,
  output logic             DSP_ENABLE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLANK_FRAMES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TIMEOUT_CYC - TMO_W'(1);

  logic [1:0]         state,     state_nxt;
  logic [HOLD_W-1:0]  hold_cnt,  hold_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_nxt;
  logic [TMO_W-1:0]   tmo_cnt,   tmo_nxt;
  resol_t             pend,      pend_nxt;
  resol_t             resol_nxt;
  logic               done_nxt, err_nxt;
  logic               fs;

  frame_start_det u_fs (
    .hcnt     (HCNT),
    .vcnt     (VCNT),
    .sync_rst (SYNC_RST),
    .fs       (fs)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt = state;
    hold_nxt  = hold_cnt;
    frame_nxt = frame_cnt;
    tmo_nxt   = tmo_cnt;
    pend_nxt  = pend;
    resol_nxt = RESOL;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_SETTLE;
          hold_nxt  = '0;
          frame_nxt = '0;
          tmo_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end

      ST_SETTLE: begin
        // A frame start beats a simultaneous timeout.
        if (fs) begin
          frame_nxt = frame_cnt + FRAME_W'(1);
          tmo_nxt   = '0;
          if (frame_cnt == FRAME_LAST) begin
            state_nxt = ST_RUN;
            done_nxt  = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          // Retry the power-up with the same RESOL.
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end

      ST_RUN: begin
        if (REQ_VALID && REQ_READY) begin
          if (!resol_valid(REQ_RESOL)) begin
            err_nxt = 1'b1;
          end else if (REQ_RESOL == RESOL) begin
            done_nxt = 1'b1;
          end else begin
            pend_nxt  = REQ_RESOL;
            state_nxt = ST_WAIT_FS;
          end
        end
      end

      ST_WAIT_FS: begin
        // Only frame starts seen in this state count, so a handshake that
        // coincides with a frame start waits for the following one.
        if (fs) begin
          resol_nxt = pend;
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end

      default: begin
        state_nxt = ST_HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge DCLK) begin
    if (!DRST_X) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      frame_cnt <= '0;
      tmo_cnt   <= '0;
      pend      <= DEF_RESOL;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      frame_cnt <= frame_nxt;
      tmo_cnt   <= tmo_nxt;
      pend      <= pend_nxt;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state itself; RESOL and SYNC_RST therefore rise together.
  always_ff @(posedge DCLK) begin
    if (!DRST_X) begin
      RESOL      <= DEF_RESOL;
      SYNC_RST   <= 1'b1;
      DSP_ENABLE <= 1'b0;
      BUSY       <= 1'b1;
      REQ_READY  <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      RESOL      <= resol_nxt;
      SYNC_RST   <= (state_nxt == ST_HOLD);
      DSP_ENABLE <= (state_nxt == ST_RUN);
      BUSY       <= (state_nxt != ST_RUN);
      REQ_READY  <= (state_nxt == ST_RUN);
      DONE       <= done_nxt;
      ERR        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_mode_ctrl
// Drives disp_mode_ctrl with a small syncgen model (10 x 4 frame) and checks
// each DONE/ERR event against an expected-event queue filled when the
// stimulus is applied. A monitor tracks output relationships that must hold
// on every cycle.
// ---------------------------------------------------------------------------
module tb_disp_mode_ctrl;

  localparam int H_TOT = 10;
  localparam int V_TOT = 4;
  localparam int F     = H_TOT * V_TOT;
  localparam int HOLD  = 16;
  localparam int BLANK = 2;
  localparam int TMO   = 1000;
  localparam int PWRUP = HOLD + (BLANK - 1) * F + 1;

  logic        DCLK = 1'b0;
  logic        DRST_X = 1'b0;
  logic [1:0]  REQ_RESOL = 2'd0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [10:0] HCNT, VCNT;
  logic [1:0]  RESOL;
  logic        SYNC_RST, DSP_ENABLE, BUSY, DONE, ERR;
  logic        stall = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         is_err;
    logic [1:0] resol;
    int         cyc;
    int         srst_hi;
    int         rise_k;
    int         mute_k;
  } exp_t;

  typedef struct {
    bit         is_err;
    logic [1:0] resol;
    int         cyc;
    int         srst_hi;
    int         rise_k;
    int         chg_k;
    int         mute_k;
    int         rdy_k;
    logic       en;
    logic       rdy;
  } obs_t;

  exp_t exp_q[$];

  disp_mode_ctrl #(
    .HOLD_CYC     (HOLD),
    .BLANK_FRAMES (BLANK),
    .TIMEOUT_CYC  (24'(TMO)),
    .DEF_RESOL    (2'd0)
  ) dut (
    .DCLK       (DCLK),
    .DRST_X     (DRST_X),
    .REQ_RESOL  (REQ_RESOL),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .HCNT       (HCNT),
    .VCNT       (VCNT),
    .RESOL      (RESOL),
    .SYNC_RST   (SYNC_RST),
    .DSP_ENABLE (DSP_ENABLE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 DCLK = ~DCLK;

  // syncgen model: counters held at zero in reset, frozen when stalled.
  always @(posedge DCLK) begin
    if (SYNC_RST !== 1'b0) begin
      HCNT <= '0;
      VCNT <= '0;
    end else if (!stall) begin
      if (HCNT == 11'(H_TOT - 1)) begin
        HCNT <= '0;
        VCNT <= (VCNT == 11'(V_TOT - 1)) ? 11'd0 : VCNT + 11'd1;
      end else begin
        HCNT <= HCNT + 11'd1;
      end
    end
  end

  // Per-cycle relationships between outputs.
  int         mon_link_viol  = 0;
  int         mon_resol_viol = 0;
  int         mon_pulse_viol = 0;
  logic [1:0] mon_prev_resol;
  logic       mon_prev_done = 1'b0;
  logic       mon_prev_err  = 1'b0;

  always @(negedge DCLK) begin
    if (BUSY !== ~REQ_READY || DSP_ENABLE !== REQ_READY) mon_link_viol++;
    if (RESOL !== mon_prev_resol && SYNC_RST !== 1'b1) mon_resol_viol++;
    if ((DONE === 1'b1 && mon_prev_done === 1'b1) || (ERR === 1'b1 && mon_prev_err === 1'b1) ||
        (DONE === 1'b1 && ERR === 1'b1) || (DONE === 1'b1 && DSP_ENABLE !== 1'b1))
      mon_pulse_viol++;
    mon_prev_resol = RESOL;
    mon_prev_done  = DONE;
    mon_prev_err   = ERR;
  end

  function automatic int frame_pos();
    return int'(VCNT) * H_TOT + int'(HCNT);
  endfunction

  // Cycles from the request sample until the frame start WAIT_FS acts on.
  function automatic int wait_to_fs(input int pos);
    return (pos == 0) ? F : F - pos;
  endfunction

  // Step negedges until DONE or ERR; sample 0 is the current cycle.
  task automatic wait_evt(input int budget, output bit seen, output obs_t o);
    logic [1:0] r0;
    logic       prev_srst;
    o = '{default: 0};
    o.srst_hi = (SYNC_RST === 1'b1) ? 1 : 0;
    o.rise_k  = -1;
    o.chg_k   = -1;
    o.mute_k  = (DSP_ENABLE === 1'b0) ? 0 : -1;
    o.rdy_k   = (REQ_READY === 1'b0) ? 0 : -1;
    r0        = RESOL;
    prev_srst = SYNC_RST;
    seen      = 1'b0;
    for (int k = 1; k <= budget && !seen; k++) begin
      @(negedge DCLK);
      if (k == 1) REQ_VALID = 1'b0;
      if (SYNC_RST === 1'b1) o.srst_hi++;
      if (SYNC_RST === 1'b1 && prev_srst === 1'b0 && o.rise_k < 0) o.rise_k = k;
      if (RESOL !== r0 && o.chg_k < 0) o.chg_k = k;
      if (DSP_ENABLE === 1'b0 && o.mute_k < 0) o.mute_k = k;
      if (REQ_READY === 1'b0 && o.rdy_k < 0) o.rdy_k = k;
      prev_srst = SYNC_RST;
      if (DONE === 1'b1 || ERR === 1'b1) begin
        seen     = 1'b1;
        o.is_err = (ERR === 1'b1);
        o.resol  = RESOL;
        o.cyc    = k;
        o.en     = DSP_ENABLE;
        o.rdy    = REQ_READY;
      end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL evt_timeout: no DONE/ERR within %0d cycles", budget);
    end
  endtask

  task automatic wait_pos(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * F && !hit; i++) begin
      if (frame_pos() == p && SYNC_RST === 1'b0) hit = 1'b1;
      else @(negedge DCLK);
    end
    if (!hit) begin
      n_checks++; n_errors++;
      $display("FAIL pos_timeout: frame position %0d never reached", p);
    end
  endtask

  task automatic push_pwrup();
    exp_q.push_back('{is_err: 1'b0, resol: 2'd0, cyc: PWRUP, srst_hi: HOLD, rise_k: -1, mute_k: 0});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge DCLK);
    n_checks++; if (RESOL !== 2'd0)      begin n_errors++; $display("FAIL rst_resol: got %0d want 0", RESOL); end
    n_checks++; if (SYNC_RST !== 1'b1)   begin n_errors++; $display("FAIL rst_sync_rst: got %b want 1", SYNC_RST); end
    n_checks++; if (DSP_ENABLE !== 1'b0) begin n_errors++; $display("FAIL rst_dsp_enable: got %b want 0", DSP_ENABLE); end
    n_checks++; if (BUSY !== 1'b1)       begin n_errors++; $display("FAIL rst_busy: got %b want 1", BUSY); end
    n_checks++; if (REQ_READY !== 1'b0)  begin n_errors++; $display("FAIL rst_ready: got %b want 0", REQ_READY); end
    n_checks++; if (DONE !== 1'b0)       begin n_errors++; $display("FAIL rst_done: got %b want 0", DONE); end
    n_checks++; if (ERR !== 1'b0)        begin n_errors++; $display("FAIL rst_err: got %b want 0", ERR); end
  endtask

  task automatic test_power_up();
    obs_t o; exp_t e; bit seen;
    DRST_X = 1'b1;
    push_pwrup();
    wait_evt(PWRUP + 200, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.is_err != e.is_err)   begin n_errors++; $display("FAIL pwr_kind: got err=%0d want %0d", o.is_err, e.is_err); end
      n_checks++; if (o.cyc != e.cyc)         begin n_errors++; $display("FAIL pwr_latency: got %0d want %0d", o.cyc, e.cyc); end
      n_checks++; if (o.srst_hi != e.srst_hi) begin n_errors++; $display("FAIL pwr_sync_rst_len: got %0d want %0d", o.srst_hi, e.srst_hi); end
      n_checks++; if (o.resol !== e.resol || o.chg_k != -1) begin n_errors++; $display("FAIL pwr_resol: got %0d (chg at %0d) want %0d unchanged", o.resol, o.chg_k, e.resol); end
      n_checks++; if (o.en !== 1'b1 || o.rdy !== 1'b1) begin n_errors++; $display("FAIL pwr_enable: got en=%b rdy=%b want 1/1", o.en, o.rdy); end
    end
  endtask

  task automatic test_switch();
    obs_t o; exp_t e; bit seen; int w;
    wait_pos(15);
    w = wait_to_fs(frame_pos());
    REQ_RESOL = 2'd2; REQ_VALID = 1'b1;
    exp_q.push_back('{is_err: 1'b0, resol: 2'd2, cyc: w + 1 + PWRUP, srst_hi: HOLD, rise_k: w + 1, mute_k: 1});
    wait_evt(3 * F + HOLD + 50, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.mute_k != e.mute_k || o.rdy_k != 1) begin n_errors++; $display("FAIL sw_mute: got mute@%0d rdy_low@%0d want %0d", o.mute_k, o.rdy_k, e.mute_k); end
      n_checks++; if (o.rise_k != e.rise_k)   begin n_errors++; $display("FAIL sw_sync_rst_rise: got %0d want %0d", o.rise_k, e.rise_k); end
      n_checks++; if (o.chg_k != e.rise_k)    begin n_errors++; $display("FAIL sw_resol_change: got %0d want %0d", o.chg_k, e.rise_k); end
      n_checks++; if (o.srst_hi != e.srst_hi) begin n_errors++; $display("FAIL sw_sync_rst_len: got %0d want %0d", o.srst_hi, e.srst_hi); end
      n_checks++; if (o.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL sw_done: got err=%0d at %0d want done at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.resol !== e.resol)    begin n_errors++; $display("FAIL sw_resol: got %0d want %0d", o.resol, e.resol); end
      n_checks++; if (o.rdy !== 1'b1 || o.en !== 1'b1) begin n_errors++; $display("FAIL sw_ready: got rdy=%b en=%b want 1/1", o.rdy, o.en); end
    end
  endtask

  task automatic test_reserved();
    obs_t o; exp_t e; bit seen;
    REQ_RESOL = 2'd3; REQ_VALID = 1'b1;
    exp_q.push_back('{is_err: 1'b1, resol: 2'd2, cyc: 1, srst_hi: 0, rise_k: -1, mute_k: -1});
    wait_evt(20, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.is_err != e.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL rsvd_err: got err=%0d at %0d want err at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.resol !== e.resol)    begin n_errors++; $display("FAIL rsvd_resol: got %0d want %0d", o.resol, e.resol); end
      n_checks++; if (o.mute_k != e.mute_k || o.en !== 1'b1) begin n_errors++; $display("FAIL rsvd_mute: got mute@%0d en=%b want none/1", o.mute_k, o.en); end
    end
  endtask

  task automatic test_same();
    obs_t o; exp_t e; bit seen;
    REQ_RESOL = 2'd2; REQ_VALID = 1'b1;
    exp_q.push_back('{is_err: 1'b0, resol: 2'd2, cyc: 1, srst_hi: 0, rise_k: -1, mute_k: -1});
    wait_evt(20, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.is_err != e.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL same_done: got err=%0d at %0d want done at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.mute_k != e.mute_k)   begin n_errors++; $display("FAIL same_mute: got mute@%0d want none", o.mute_k); end
      n_checks++; if (o.srst_hi != e.srst_hi) begin n_errors++; $display("FAIL same_sync_rst: got %0d high cycles want %0d", o.srst_hi, e.srst_hi); end
    end
  endtask

  task automatic test_reset_in_wait();
    obs_t o; exp_t e; bit seen;
    wait_pos(10);
    REQ_RESOL = 2'd1; REQ_VALID = 1'b1;
    @(negedge DCLK);
    REQ_VALID = 1'b0;
    n_checks++; if (DSP_ENABLE !== 1'b0 || REQ_READY !== 1'b0 || BUSY !== 1'b1) begin n_errors++; $display("FAIL wfs_handshake: got en=%b rdy=%b busy=%b want 0/0/1", DSP_ENABLE, REQ_READY, BUSY); end
    DRST_X = 1'b0;
    repeat (2) @(negedge DCLK);
    n_checks++; if (RESOL !== 2'd0)    begin n_errors++; $display("FAIL wfs_rst_resol: got %0d want 0", RESOL); end
    n_checks++; if (SYNC_RST !== 1'b1) begin n_errors++; $display("FAIL wfs_rst_sync_rst: got %b want 1", SYNC_RST); end
    DRST_X = 1'b1;
    push_pwrup();
    wait_evt(PWRUP + 200, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL wfs_pwr_latency: got err=%0d at %0d want done at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.resol !== e.resol || o.chg_k != -1) begin n_errors++; $display("FAIL wfs_pending_dropped: got %0d (chg at %0d) want %0d", o.resol, o.chg_k, e.resol); end
      n_checks++; if (o.srst_hi != e.srst_hi) begin n_errors++; $display("FAIL wfs_sync_rst_len: got %0d want %0d", o.srst_hi, e.srst_hi); end
    end
  endtask

  task automatic test_req_at_fs();
    obs_t o; exp_t e; bit seen; int w;
    wait_pos(0);
    w = wait_to_fs(frame_pos());
    REQ_RESOL = 2'd1; REQ_VALID = 1'b1;
    exp_q.push_back('{is_err: 1'b0, resol: 2'd1, cyc: w + 1 + PWRUP, srst_hi: HOLD, rise_k: w + 1, mute_k: 1});
    wait_evt(3 * F + HOLD + 50, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.rise_k != e.rise_k || o.chg_k != e.rise_k) begin n_errors++; $display("FAIL fs_req_rise: got rst@%0d resol@%0d want %0d", o.rise_k, o.chg_k, e.rise_k); end
      n_checks++; if (o.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL fs_req_done: got err=%0d at %0d want done at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.resol !== e.resol) begin n_errors++; $display("FAIL fs_req_resol: got %0d want %0d", o.resol, e.resol); end
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e; bit seen; int j;
    REQ_RESOL = 2'd0; REQ_VALID = 1'b1;
    @(negedge DCLK);
    REQ_VALID = 1'b0;
    for (int i = 0; i < F + 4 && SYNC_RST !== 1'b1; i++) @(negedge DCLK);
    for (int i = 0; i < HOLD + 4 && SYNC_RST !== 1'b0; i++) @(negedge DCLK);
    j = 0;
    while (HCNT != 11'd5 && j < 20) begin @(negedge DCLK); j++; end
    stall = 1'b1;
    exp_q.push_back('{is_err: 1'b1, resol: 2'd0, cyc: TMO + 1 - j, srst_hi: 1, rise_k: TMO + 1 - j, mute_k: 0});
    wait_evt(TMO + 50, seen, o);
    e = exp_q.pop_front();
    stall = 1'b0;
    if (seen) begin
      n_checks++; if (o.is_err != e.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL tmo_err: got err=%0d at %0d want err at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.rise_k != e.rise_k) begin n_errors++; $display("FAIL tmo_hold: got sync_rst rise at %0d want %0d", o.rise_k, e.rise_k); end
      n_checks++; if (o.resol !== e.resol || o.en !== 1'b0) begin n_errors++; $display("FAIL tmo_state: got resol=%0d en=%b want %0d/0", o.resol, o.en, e.resol); end
    end
    push_pwrup();
    wait_evt(PWRUP + 200, seen, o);
    e = exp_q.pop_front();
    if (seen) begin
      n_checks++; if (o.srst_hi != e.srst_hi) begin n_errors++; $display("FAIL retry_sync_rst_len: got %0d want %0d", o.srst_hi, e.srst_hi); end
      n_checks++; if (o.is_err || o.cyc != e.cyc) begin n_errors++; $display("FAIL retry_done: got err=%0d at %0d want done at %0d", o.is_err, o.cyc, e.cyc); end
      n_checks++; if (o.resol !== e.resol) begin n_errors++; $display("FAIL retry_resol: got %0d want %0d", o.resol, e.resol); end
    end
  endtask

  task automatic test_invariants();
    @(negedge DCLK);
    n_checks++; if (mon_link_viol != 0)  begin n_errors++; $display("FAIL inv_status_link: got %0d violations want 0", mon_link_viol); end
    n_checks++; if (mon_resol_viol != 0) begin n_errors++; $display("FAIL inv_resol_stable: got %0d violations want 0", mon_resol_viol); end
    n_checks++; if (mon_pulse_viol != 0) begin n_errors++; $display("FAIL inv_pulses: got %0d violations want 0", mon_pulse_viol); end
    n_checks++; if (exp_q.size() != 0)   begin n_errors++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_switch();
    test_reserved();
    test_same();
    test_reset_in_wait();
    test_req_at_fs();
    test_timeout();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_mode_ctrl.md
# disp_mode_ctrl

Display mode controller that sequences resolution changes and power-up of the `syncgen` timing generator. It accepts a resolution request over a valid/ready handshake, mutes display output, waits for a frame boundary, and holds `syncgen` in reset while `RESOL` switches. It then releases `syncgen` and re-enables output only after a programmable number of clean frames. It sits between the register/control interface and `syncgen` in the pattern pipeline, driving `syncgen`'s `DRST` and `RESOL`.

## Interface
- `HOLD_CYC`, 16: cycles `SYNC_RST` is held high per switch (≥2).
- `BLANK_FRAMES`, 2: frame starts counted after release before output is enabled (1–15).
- `TIMEOUT_CYC`, 24'd4_000_000: maximum cycles between frame starts while settling.
- `DEF_RESOL`, 2'd0: resolution applied after reset.
- `DCLK`  in  1  display clock; the only clock.
- `DRST_X`  in  1  reset, synchronous, active-low.
- `REQ_RESOL`  in  2  requested resolution code.
- `REQ_VALID`  in  1  request strobe.
- `REQ_READY`  out  1  high only in RUN.
- `HCNT`, `VCNT`  in  11 each  counters from `syncgen`.
- `RESOL`  out  2  resolution to `syncgen`.
- `SYNC_RST`  out  1  active-high reset to `syncgen` `DRST`.
- `DSP_ENABLE`  out  1  output gate for the pixel path.
- `BUSY`  out  1  high whenever the state is not RUN.
- `DONE`  out  1  one-cycle pulse when a switch completes.
- `ERR`  out  1  one-cycle pulse on an invalid request or a timeout.

## Operation
- States: HOLD, SETTLE, RUN, WAIT_FS.
- Reset (`DRST_X`=0 at a `DCLK` edge) puts every output in a defined state:
  - state=HOLD
  - `RESOL`=`DEF_RESOL`, `SYNC_RST`=1, `DSP_ENABLE`=0, `BUSY`=1
  - `REQ_READY`=0, `DONE`=0, `ERR`=0
  - hold counter=0, frame counter=0, timeout counter=0
- Reset mid-operation aborts any sequence and restarts at HOLD.
- HOLD:
  - `SYNC_RST`=1 and the hold counter increments.
  - At count `HOLD_CYC`-1, go to SETTLE and clear the frame and timeout counters.
- SETTLE:
  - `SYNC_RST`=0, `DSP_ENABLE`=0.
  - A frame start is any cycle with `HCNT`==0, `VCNT`==0 and `SYNC_RST`==0. The first cycle after release counts.
  - Each frame start increments the frame counter and clears the timeout counter.
  - When the frame counter reaches `BLANK_FRAMES`, go to RUN and pulse `DONE`.
  - If the timeout counter reaches `TIMEOUT_CYC`-1, pulse `ERR` and return to HOLD (retry, same `RESOL`).
- RUN: `DSP_ENABLE`=1, `REQ_READY`=1. A handshake fires on `REQ_VALID`&&`REQ_READY`:
  - `REQ_RESOL`==2'b11 (reserved): reject, pulse `ERR`, stay in RUN.
  - `REQ_RESOL`==`RESOL`: stay in RUN, pulse `DONE`, output is never muted.
  - Any other valid code: latch it into a pending register and go to WAIT_FS.
- WAIT_FS:
  - `DSP_ENABLE`=0.
  - At the next frame start, load the pending code into `RESOL` and go to HOLD.
- `REQ_VALID` outside RUN is ignored; requesters hold it until `REQ_READY`.
- Counter widths: hold 8-bit, frame 4-bit, timeout 24-bit. Parameters outside their ranges are illegal.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Handshake at edge N: `REQ_READY`=0, `BUSY`=1 and `DSP_ENABLE`=0 from cycle N+1.
- `RESOL` changes on the same edge that `SYNC_RST` rises. It is never changed while `SYNC_RST`=0.
- `SYNC_RST` stays high for exactly `HOLD_CYC` cycles.
- `DONE` is asserted in the first RUN cycle, coincident with `DSP_ENABLE` rising.
- Power-up latency from reset release to `DSP_ENABLE`=1 is `HOLD_CYC` + cycles to the `BLANK_FRAMES`-th frame start + 1.
- Simultaneous timeout and frame start in SETTLE: the frame start wins and the timeout counter clears.
- Handshake in the same cycle as a frame start in RUN: WAIT_FS waits for the next frame start, not the current one.

## Structure
- Package `disp_pkg`:
  - resolution codes `RESOL_VGA`=0, `RESOL_XGA`=1, `RESOL_SXGA`=2, `RESOL_RSVD`=3
  - state encoding localparams
  - counter width constants
- One sub-module `frame_start_det`: compares `HCNT`/`VCNT` with zero, gated by `SYNC_RST`, and produces the `fs` pulse. It is reused by the pixel path.
- The FSM and counters live in a single always block per register group.

## Test plan
- Reset release with `HOLD_CYC`=16, `BLANK_FRAMES`=2 and a `syncgen` model at `RESOL`=0 → `SYNC_RST` high for 16 cycles, then `DSP_ENABLE`=1 and `DONE` pulse one cycle after the 2nd frame start; `RESOL`=0 throughout.
- In RUN, request `REQ_RESOL`=2 mid-frame → `DSP_ENABLE` falls next cycle; `RESOL`=2 and `SYNC_RST` rise together at the next frame start; `REQ_READY` returns with `DONE` after 2 frames.
- Request `REQ_RESOL`=3 → `ERR` one cycle, `RESOL` unchanged, `DSP_ENABLE` stays 1.
- Request equal to current `RESOL` → `DONE` next cycle, no mute, no `SYNC_RST`.
- Stall the `syncgen` model (`HCNT` frozen at 5) during SETTLE with `TIMEOUT_CYC`=1000 → `ERR` at cycle 1000, re-enter HOLD, `SYNC_RST` high for 16 cycles.
- Assert `DRST_X`=0 during WAIT_FS with a pending code of 1 → after release `RESOL`=`DEF_RESOL`, the pending code is discarded and the power-up sequence repeats.
